// File: rtl/dsp_mem_seq_ctrl.sv
// Staged reset/enable bring-up for a retimer, a set of memory banks and a
// frame-sync block, with a programmable per-step dwell.
module dsp_mem_seq_ctrl #(
  parameter int NUM_BANKS    = 16,
  parameter int FRAME_LENGTH = 64,
  parameter int DlyWidth     = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [NUM_BANKS-1:0]    i_bank_mask,
  input  logic [DlyWidth-1:0]     i_cfg_dly,
  input  logic [FRAME_LENGTH-1:0] i_cfg_fs_syncword,
  output logic                    o_rst_retime,
  output logic [NUM_BANKS-1:0]    o_wrst_bank,
  output logic [NUM_BANKS-1:0]    o_rrst_bank,
  output logic                    o_rrst_fs,
  output logic                    o_en_retime,
  output logic [NUM_BANKS-1:0]    o_en_bank,
  output logic                    o_en_fs,
  output logic [FRAME_LENGTH-1:0] o_cfg_fs_syncword,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [2:0]              o_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    RETIME = 3'd2,
    BANK   = 3'd3,
    FS     = 3'd4,
    RUN    = 3'd5
  } state_t;

  state_t               state;
  logic [DlyWidth-1:0]  cnt;
  logic [DlyWidth-1:0]  dly_q;
  logic [NUM_BANKS-1:0] rem;
  logic [NUM_BANKS-1:0] low;

  // Banks still waiting; the lowest one left is released next.
  assign low     = rem & (~rem + NUM_BANKS'(1));
  assign o_state = state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state             <= IDLE;
      cnt               <= '0;
      dly_q             <= '0;
      rem               <= '0;
      o_rst_retime      <= 1'b1;
      o_wrst_bank       <= '1;
      o_rrst_bank       <= '1;
      o_rrst_fs         <= 1'b1;
      o_en_retime       <= 1'b0;
      o_en_bank         <= '0;
      o_en_fs           <= 1'b0;
      o_cfg_fs_syncword <= '0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
    end else if (i_abort) begin
      state        <= IDLE;
      cnt          <= '0;
      rem          <= '0;
      o_rst_retime <= 1'b1;
      o_wrst_bank  <= '1;
      o_rrst_bank  <= '1;
      o_rrst_fs    <= 1'b1;
      o_en_retime  <= 1'b0;
      o_en_bank    <= '0;
      o_en_fs      <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (i_start) begin
            state             <= HOLD;
            cnt               <= i_cfg_dly;
            dly_q             <= i_cfg_dly;
            rem               <= i_bank_mask;
            o_cfg_fs_syncword <= i_cfg_fs_syncword;
            o_rst_retime      <= 1'b1;
            o_wrst_bank       <= '1;
            o_rrst_bank       <= '1;
            o_rrst_fs         <= 1'b1;
            o_en_retime       <= 1'b0;
            o_en_bank         <= '0;
            o_en_fs           <= 1'b0;
            o_busy            <= 1'b1;
            o_done            <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state        <= RETIME;
            cnt          <= dly_q;
            o_rst_retime <= 1'b0;
            o_en_retime  <= 1'b1;
          end else begin
            cnt <= cnt - DlyWidth'(1);
          end
        end
        RETIME, BANK: begin
          if (cnt == '0) begin
            cnt <= dly_q;
            if (rem != '0) begin
              state       <= BANK;
              rem         <= rem & ~low;
              o_wrst_bank <= o_wrst_bank & ~low;
              o_rrst_bank <= o_rrst_bank & ~low;
              o_en_bank   <= o_en_bank | low;
            end else begin
              state     <= FS;
              o_rrst_fs <= 1'b0;
              o_en_fs   <= 1'b1;
            end
          end else begin
            cnt <= cnt - DlyWidth'(1);
          end
        end
        FS: begin
          if (cnt == '0) begin
            state  <= RUN;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
            cnt <= cnt - DlyWidth'(1);
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mem_seq_ctrl.sv
// Randomized bench for dsp_mem_seq_ctrl against a timeline model of the
// bring-up sequence.
module tb_dsp_mem_seq_ctrl;

  localparam int NB = 4;
  localparam int FL = 64;
  localparam int DW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic          i_abort;
  logic [NB-1:0] i_bank_mask;
  logic [DW-1:0] i_cfg_dly;
  logic [FL-1:0] i_cfg_fs_syncword;
  logic          o_rst_retime;
  logic [NB-1:0] o_wrst_bank;
  logic [NB-1:0] o_rrst_bank;
  logic          o_rrst_fs;
  logic          o_en_retime;
  logic [NB-1:0] o_en_bank;
  logic          o_en_fs;
  logic [FL-1:0] o_cfg_fs_syncword;
  logic          o_busy;
  logic          o_done;
  logic [2:0]    o_state;

  int total = 0;
  int bad   = 0;

  dsp_mem_seq_ctrl #(
    .NUM_BANKS(NB),
    .FRAME_LENGTH(FL),
    .DlyWidth(DW)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_abort(i_abort),
    .i_bank_mask(i_bank_mask),
    .i_cfg_dly(i_cfg_dly),
    .i_cfg_fs_syncword(i_cfg_fs_syncword),
    .o_rst_retime(o_rst_retime),
    .o_wrst_bank(o_wrst_bank),
    .o_rrst_bank(o_rrst_bank),
    .o_rrst_fs(o_rrst_fs),
    .o_en_retime(o_en_retime),
    .o_en_bank(o_en_bank),
    .o_en_fs(o_en_fs),
    .o_cfg_fs_syncword(o_cfg_fs_syncword),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Banks released t cycles after the start edge: the j-th set bit
  // (in ascending order) opens at L*(2+j).
  function automatic logic [NB-1:0] rel_at(int t, logic [NB-1:0] m, int l);
    logic [NB-1:0] r;
    int j;
    r = '0;
    j = 0;
    for (int k = 0; k < NB; k++) begin
      if (m[k]) begin
        if (t >= l * (2 + j)) r[k] = 1'b1;
        j++;
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] state_at(int t, int n, int l);
    if (t < l) return 3'd1;
    if (t < 2 * l) return 3'd2;
    if (t < (2 + n) * l) return 3'd3;
    if (t < (3 + n) * l) return 3'd4;
    return 3'd5;
  endfunction

  // Start a sequence and follow it for stop_t cycles (or to completion when
  // stop_t < 0), scrambling the config inputs and pulsing start mid-run.
  task automatic run_seq(input logic [NB-1:0] m, input int d,
                         input logic [FL-1:0] sw, input int stop_t);
    int l;
    int n;
    int last;
    logic [2:0] es;
    logic [NB-1:0] rel;
    logic eb;
    l = d + 1;
    n = $countones(m);
    last = (stop_t >= 0) ? stop_t : l * (3 + n) + 2;
    i_bank_mask = m;
    i_cfg_dly = DW'(d);
    i_cfg_fs_syncword = sw;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int t = 0; t <= last; t++) begin
      es  = state_at(t, n, l);
      rel = rel_at(t, m, l);
      eb  = (es >= 3'd1) && (es <= 3'd4);
      total++;
      if (o_state !== es) begin
        bad++;
        $display("FAIL seq_state t=%0d got=%0d exp=%0d", t, o_state, es);
      end
      total++;
      if (o_busy !== eb || o_done !== (es == 3'd5)) begin
        bad++;
        $display("FAIL seq_status t=%0d busy=%b done=%b exp_state=%0d",
                 t, o_busy, o_done, es);
      end
      total++;
      if (o_rst_retime !== (t < l) || o_en_retime !== (t >= l)) begin
        bad++;
        $display("FAIL seq_retime t=%0d rst=%b en=%b exp_rst=%b",
                 t, o_rst_retime, o_en_retime, (t < l));
      end
      total++;
      if (o_en_bank !== rel || o_wrst_bank !== ~rel || o_rrst_bank !== ~rel) begin
        bad++;
        $display("FAIL seq_bank t=%0d en=%b wrst=%b rrst=%b exp_en=%b",
                 t, o_en_bank, o_wrst_bank, o_rrst_bank, rel);
      end
      total++;
      if (o_rrst_fs !== (t < (2 + n) * l) || o_en_fs !== (t >= (2 + n) * l)) begin
        bad++;
        $display("FAIL seq_fs t=%0d rst=%b en=%b", t, o_rrst_fs, o_en_fs);
      end
      total++;
      if (o_cfg_fs_syncword !== sw) begin
        bad++;
        $display("FAIL seq_sync t=%0d got=%h exp=%h", t, o_cfg_fs_syncword, sw);
      end
      if (t < last) begin
        i_bank_mask = NB'($urandom);
        i_cfg_dly = DW'($urandom);
        i_cfg_fs_syncword = {$urandom, $urandom};
        i_start = eb ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
    end
    i_start = 1'b0;
  endtask

  task automatic check_idle(input string name, input bit chk_sync);
    total++;
    if (o_state !== 3'd0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL %s_status state=%0d busy=%b done=%b exp=0/0/0",
               name, o_state, o_busy, o_done);
    end
    total++;
    if (o_rst_retime !== 1'b1 || o_wrst_bank !== '1 || o_rrst_bank !== '1 ||
        o_rrst_fs !== 1'b1) begin
      bad++;
      $display("FAIL %s_resets got=%b %b %b %b exp=all ones", name,
               o_rst_retime, o_wrst_bank, o_rrst_bank, o_rrst_fs);
    end
    total++;
    if (o_en_retime !== 1'b0 || o_en_bank !== '0 || o_en_fs !== 1'b0) begin
      bad++;
      $display("FAIL %s_enables got=%b %b %b exp=all zero", name,
               o_en_retime, o_en_bank, o_en_fs);
    end
    if (chk_sync) begin
      total++;
      if (o_cfg_fs_syncword !== '0) begin
        bad++;
        $display("FAIL %s_sync got=%h exp=0", name, o_cfg_fs_syncword);
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_bank_mask = '0;
    i_cfg_dly = '0;
    i_cfg_fs_syncword = '0;
    tick();
    tick();
    check_idle("reset", 1'b1);
    i_rst = 1'b0;
    tick();
    tick();
    check_idle("post_reset", 1'b1);
  endtask

  task automatic test_ref_case();
    run_seq(4'b1011, 2, 64'hDEAD_BEEF_0123_4567, -1);
  endtask

  task automatic test_zero_mask();
    run_seq(4'b0000, 0, 64'h1111_2222_3333_4444, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_seq(NB'($urandom), $urandom_range(0, 4), {$urandom, $urandom}, -1);
  endtask

  task automatic test_back_to_back();
    run_seq(4'b0110, 1, 64'hA5A5_5A5A_0F0F_F0F0, -1);
    run_seq(4'b1001, 3, 64'h0123_4567_89AB_CDEF, -1);
  endtask

  task automatic test_abort();
    run_seq(4'b1011, 2, 64'hCAFE_F00D_0000_0001, 10);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check_idle("abort", 1'b0);
    tick();
    check_idle("abort_hold", 1'b0);
  endtask

  task automatic test_abort_start_in_run();
    run_seq(4'b0101, 1, 64'h7777_8888_9999_AAAA, -1);
    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    check_idle("abort_win", 1'b0);
    tick();
    tick();
    check_idle("abort_norestart", 1'b0);
  endtask

  task automatic test_async_reset();
    run_seq(4'b0001, 3, 64'hFEED_FACE_1234_5678, 13);
    #3;
    i_rst = 1'b1;
    #1;
    check_idle("async_rst", 1'b1);
    #1;
    i_rst = 1'b0;
    tick();
    check_idle("rst_wait", 1'b1);
    run_seq(4'b1100, 1, 64'h0BAD_C0DE_5555_6666, -1);
  endtask

  task automatic test_long_dly();
    run_seq(4'b0001, 255, 64'h8000_0000_0000_0001, -1);
  endtask

  initial begin
    test_reset();
    test_ref_case();
    test_zero_mask();
    test_random();
    test_back_to_back();
    test_abort();
    test_abort_start_in_run();
    test_async_reset();
    test_long_dly();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
